smc_wr_seq_lite18: RTL and testbench

//   Write-cycle sequencer for the lite SMC write path. Takes one write request
//   at a time and runs programmable setup, strobe and hold phases.

---
 rtl/smc_wr_seq_lite18.sv | 152 +++++++++++++++
 tb/tb_smc_wr_seq_lite18.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/smc_wr_seq_lite18.sv
// Write-cycle sequencer for the lite SMC write path.
// Accepts one write request at a time and walks it through programmable
// setup, strobe and hold phases, driving the gate, byte-enable and strobe
// signals that smc_wr_enable_lite18 puts onto the external pins.
// Every output is registered and decoded from the next state, so each output
// changes on the same edge as the state it belongs to.
module smc_wr_seq_lite18 #(
    parameter int CNT_W18 = 4
) (
    input  logic               sys_clk18,
    input  logic               n_sys_reset18,
    input  logic               wr_req18,
    input  logic [3:0]         wr_be18,
    input  logic [CNT_W18-1:0] cfg_setup18,
    input  logic [CNT_W18-1:0] cfg_strobe18,
    input  logic [CNT_W18-1:0] cfg_hold18,
    output logic               wr_ack18,
    output logic               wr_done18,
    output logic               busy18,
    output logic               r_full18,
    output logic [3:0]         n_r_we18,
    output logic               n_r_wr18
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [CNT_W18-1:0] CNT_ONE = CNT_W18'(1);

    state_t             state, state_nxt;
    logic [CNT_W18-1:0] cnt, cnt_nxt;
    logic [3:0]         be_q, be_nxt;
    logic [CNT_W18-1:0] strobe_q, strobe_nxt;
    logic [CNT_W18-1:0] hold_q, hold_nxt;

    logic               ack_nxt, done_nxt, busy_nxt, full_nxt, wr_nxt;
    logic [3:0]         we_nxt;

    // Counter preload for the strobe phase: a zero width still gives one cycle.
    function automatic logic [CNT_W18-1:0] strobe_last(input logic [CNT_W18-1:0] s);
        return (s == '0) ? '0 : s - CNT_ONE;
    endfunction

    // State, phase counter, request latches and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge sys_clk18 or negedge n_sys_reset18) begin
        if (!n_sys_reset18) begin
            state     <= IDLE;
            cnt       <= '0;
            be_q      <= '0;
            strobe_q  <= '0;
            hold_q    <= '0;
            wr_ack18  <= 1'b0;
            wr_done18 <= 1'b0;
            busy18    <= 1'b0;
            r_full18  <= 1'b0;
            n_r_we18  <= 4'hF;
            n_r_wr18  <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            be_q      <= be_nxt;
            strobe_q  <= strobe_nxt;
            hold_q    <= hold_nxt;
            wr_ack18  <= ack_nxt;
            wr_done18 <= done_nxt;
            busy18    <= busy_nxt;
            r_full18  <= full_nxt;
            n_r_we18  <= we_nxt;
            n_r_wr18  <= wr_nxt;
        end
    end

    // Next-state, counter and latch update, then output decode from the next state.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_nxt  = state;
        cnt_nxt    = cnt;
        be_nxt     = be_q;
        strobe_nxt = strobe_q;
        hold_nxt   = hold_q;

        unique case (state)
            IDLE: begin
                if (wr_req18) begin
                    // The request's lanes and timing are frozen here; later
                    // input changes do not affect the cycle in flight.
                    be_nxt     = wr_be18;
                    strobe_nxt = cfg_strobe18;
                    hold_nxt   = cfg_hold18;
                    if (cfg_setup18 != '0) begin
                        state_nxt = SETUP;
                        cnt_nxt   = cfg_setup18 - CNT_ONE;
                    end else begin
                        state_nxt = STROBE;
                        cnt_nxt   = strobe_last(cfg_strobe18);
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = strobe_last(strobe_q);
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    if (hold_q != '0) begin
                        state_nxt = HOLD;
                        cnt_nxt   = hold_q - CNT_ONE;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Outputs follow the state being entered so they line up with it.
        ack_nxt  = (state == IDLE) && wr_req18;
        done_nxt = (state_nxt == DONE);
        busy_nxt = (state_nxt != IDLE);
        full_nxt = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);
        we_nxt   = (state_nxt == STROBE) ? ~be_nxt : 4'hF;
        wr_nxt   = (state_nxt != STROBE);
    end

endmodule

// File: tb/tb_smc_wr_seq_lite18.sv
// Directed bench for smc_wr_seq_lite18: each step drives inputs on the falling
// edge and compares every output one rising edge later, again on a falling edge.
module tb_smc_wr_seq_lite18;

    logic       sys_clk18;
    logic       n_sys_reset18;
    logic       wr_req18;
    logic [3:0] wr_be18;
    logic [3:0] cfg_setup18;
    logic [3:0] cfg_strobe18;
    logic [3:0] cfg_hold18;
    logic       wr_ack18;
    logic       wr_done18;
    logic       busy18;
    logic       r_full18;
    logic [3:0] n_r_we18;
    logic       n_r_wr18;

    int checks;
    int failures;

    smc_wr_seq_lite18 #(.CNT_W18(4)) dut (
        .sys_clk18    (sys_clk18),
        .n_sys_reset18(n_sys_reset18),
        .wr_req18     (wr_req18),
        .wr_be18      (wr_be18),
        .cfg_setup18  (cfg_setup18),
        .cfg_strobe18 (cfg_strobe18),
        .cfg_hold18   (cfg_hold18),
        .wr_ack18     (wr_ack18),
        .wr_done18    (wr_done18),
        .busy18       (busy18),
        .r_full18     (r_full18),
        .n_r_we18     (n_r_we18),
        .n_r_wr18     (n_r_wr18)
    );

    initial sys_clk18 = 1'b0;
    always #5 sys_clk18 = ~sys_clk18;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all six outputs against one hand-computed row.
    task automatic expect_out(input string tag, input logic ack, input logic done,
                              input logic busy, input logic full,
                              input logic [3:0] we, input logic wr);
        check({tag, ".ack"},  {7'd0, wr_ack18},  {7'd0, ack});
        check({tag, ".done"}, {7'd0, wr_done18}, {7'd0, done});
        check({tag, ".busy"}, {7'd0, busy18},    {7'd0, busy});
        check({tag, ".full"}, {7'd0, r_full18},  {7'd0, full});
        check({tag, ".we"},   {4'd0, n_r_we18},  {4'd0, we});
        check({tag, ".wr"},   {7'd0, n_r_wr18},  {7'd0, wr});
    endtask

    task automatic cyc();
        @(negedge sys_clk18);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        n_sys_reset18 = 1'b0;
        wr_req18      = 1'b1;
        wr_be18       = 4'hF;
        cfg_setup18   = 4'd0;
        cfg_strobe18  = 4'd0;
        cfg_hold18    = 4'd0;

        // 1. Reset held with a pending request: nothing moves.
        cyc(); expect_out("rst0", 0, 0, 0, 0, 4'hF, 1);
        cyc(); expect_out("rst1", 0, 0, 0, 0, 4'hF, 1);
        cyc(); expect_out("rst2", 0, 0, 0, 0, 4'hF, 1);
        wr_req18 = 1'b0;
        n_sys_reset18 = 1'b1;
        cyc(); expect_out("idle", 0, 0, 0, 0, 4'hF, 1);

        // 2. Basic write: setup=2 strobe=3 hold=1 be=0101.
        cfg_setup18 = 4'd2; cfg_strobe18 = 4'd3; cfg_hold18 = 4'd1; wr_be18 = 4'b0101;
        wr_req18 = 1'b1;
        cyc(); expect_out("b1", 1, 0, 1, 1, 4'hF, 1);
        wr_req18 = 1'b0;
        cyc(); expect_out("b2", 0, 0, 1, 1, 4'hF, 1);
        cyc(); expect_out("b3", 0, 0, 1, 1, 4'b1010, 0);
        cyc(); expect_out("b4", 0, 0, 1, 1, 4'b1010, 0);
        cyc(); expect_out("b5", 0, 0, 1, 1, 4'b1010, 0);
        cyc(); expect_out("b6", 0, 0, 1, 1, 4'hF, 1);
        cyc(); expect_out("b7", 0, 1, 1, 0, 4'hF, 1);
        cyc(); expect_out("b8", 0, 0, 0, 0, 4'hF, 1);

        // 3. Zero config: one strobe cycle then DONE.
        cfg_setup18 = 4'd0; cfg_strobe18 = 4'd0; cfg_hold18 = 4'd0; wr_be18 = 4'hF;
        wr_req18 = 1'b1;
        cyc(); expect_out("z1", 1, 0, 1, 1, 4'h0, 0);
        wr_req18 = 1'b0;
        cyc(); expect_out("z2", 0, 1, 1, 0, 4'hF, 1);
        cyc(); expect_out("z3", 0, 0, 0, 0, 4'hF, 1);

        // 4. Back-to-back with request held: ack every third cycle.
        cfg_setup18 = 4'd0; cfg_strobe18 = 4'd1; cfg_hold18 = 4'd0; wr_be18 = 4'b0011;
        wr_req18 = 1'b1;
        cyc(); expect_out("bb1", 1, 0, 1, 1, 4'b1100, 0);
        cyc(); expect_out("bb2", 0, 1, 1, 0, 4'hF, 1);
        cyc(); expect_out("bb3", 0, 0, 0, 0, 4'hF, 1);
        cyc(); expect_out("bb4", 1, 0, 1, 1, 4'b1100, 0);
        cyc(); expect_out("bb5", 0, 1, 1, 0, 4'hF, 1);
        cyc(); expect_out("bb6", 0, 0, 0, 0, 4'hF, 1);
        cyc(); expect_out("bb7", 1, 0, 1, 1, 4'b1100, 0);
        wr_req18 = 1'b0;
        cyc(); expect_out("bb8", 0, 1, 1, 0, 4'hF, 1);
        cyc(); expect_out("bb9", 0, 0, 0, 0, 4'hF, 1);

        // 5. Inputs changed mid-strobe do not affect the cycle in flight.
        cfg_setup18 = 4'd0; cfg_strobe18 = 4'd3; cfg_hold18 = 4'd0; wr_be18 = 4'b1000;
        wr_req18 = 1'b1;
        cyc(); expect_out("m1", 1, 0, 1, 1, 4'b0111, 0);
        wr_req18 = 1'b0;
        cfg_strobe18 = 4'd7; wr_be18 = 4'b1111; cfg_hold18 = 4'd5; cfg_setup18 = 4'd4;
        cyc(); expect_out("m2", 0, 0, 1, 1, 4'b0111, 0);
        cyc(); expect_out("m3", 0, 0, 1, 1, 4'b0111, 0);
        cyc(); expect_out("m4", 0, 1, 1, 0, 4'hF, 1);
        cyc(); expect_out("m5", 0, 0, 0, 0, 4'hF, 1);

        // 6. Reset asserted in STROBE clears outputs at once, no completion.
        cfg_setup18 = 4'd1; cfg_strobe18 = 4'd4; cfg_hold18 = 4'd0; wr_be18 = 4'b0110;
        wr_req18 = 1'b1;
        cyc(); expect_out("r1", 1, 0, 1, 1, 4'hF, 1);
        wr_req18 = 1'b0;
        cyc(); expect_out("r2", 0, 0, 1, 1, 4'b1001, 0);
        #2 n_sys_reset18 = 1'b0;
        #1 expect_out("r_async", 0, 0, 0, 0, 4'hF, 1);
        cyc(); expect_out("r_hold", 0, 0, 0, 0, 4'hF, 1);
        n_sys_reset18 = 1'b1;
        cyc(); expect_out("r_rel1", 0, 0, 0, 0, 4'hF, 1);
        cyc(); expect_out("r_rel2", 0, 0, 0, 0, 4'hF, 1);
        cfg_setup18 = 4'd0; cfg_strobe18 = 4'd2; cfg_hold18 = 4'd2; wr_be18 = 4'hF;
        wr_req18 = 1'b1;
        cyc(); expect_out("n1", 1, 0, 1, 1, 4'h0, 0);
        wr_req18 = 1'b0;
        cyc(); expect_out("n2", 0, 0, 1, 1, 4'h0, 0);
        cyc(); expect_out("n3", 0, 0, 1, 1, 4'hF, 1);
        cyc(); expect_out("n4", 0, 0, 1, 1, 4'hF, 1);
        cyc(); expect_out("n5", 0, 1, 1, 0, 4'hF, 1);
        cyc(); expect_out("n6", 0, 0, 0, 0, 4'hF, 1);

        // 7. No byte lanes: strobe still pulses, enables stay inactive.
        cfg_setup18 = 4'd0; cfg_strobe18 = 4'd1; cfg_hold18 = 4'd1; wr_be18 = 4'b0000;
        wr_req18 = 1'b1;
        cyc(); expect_out("e1", 1, 0, 1, 1, 4'hF, 0);
        wr_req18 = 1'b0;
        cyc(); expect_out("e2", 0, 0, 1, 1, 4'hF, 1);
        cyc(); expect_out("e3", 0, 1, 1, 0, 4'hF, 1);
        cyc(); expect_out("e4", 0, 0, 0, 0, 4'hF, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
